alu_mul_seq: RTL
================

# alu_mul_seq

Multi-cycle 64-bit integer multiply sequencer that drives the shared combinational `ALU_64bit` adder. It implements radix-2 shift-add multiplication, issuing one ALU add per cycle with early termination, and returns the low 64 bits of the product. It sits between the execute-stage control and the ALU operand muxes, and owns the ALU for the whole time `busy` is high.

## Interface
- No parameters. Width is fixed at 64, matching `ALU_64bit`.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request pulse; sampled only in IDLE
- `op_a`  in  64  multiplicand, two's complement
- `op_b`  in  64  multiplier, two's complement
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse when `result` becomes valid
- `result`  out  64  low 64 bits of `op_a*op_b`; held until the next DONE
- `alu_a`  out  64  to ALU port A
- `alu_b`  out  64  to ALU port B
- `alu_op`  out  4  to ALU `ALU_Op`; constant 4'b0010 (add: Ainv=0, Binv=0, Op=10)
- `alu_r`  in  64  from ALU port R; combinational, same cycle

## Operation
- Internal registers:
  - `acc` (64)
  - `mcand` (64)
  - `mplier` (64)
  - `cnt` (6)
  - `state` in {IDLE, RUN, DONE}
- IDLE:
  - If `start`=1: `acc`<=0, `mcand`<=`op_a`, `mplier`<=`op_b`, `cnt`<=0, and go to RUN.
  - If `start`=0: stay in IDLE.
- RUN, once per cycle:
  - `alu_a`=`acc`.
  - `alu_b`=`mplier[0]` ? `mcand` : 0.
  - `acc`<=`alu_r`.
  - `mcand`<=`mcand`<<1 (zero-fill).
  - `mplier`<=`mplier`>>1 (logical, zero-fill).
  - `cnt`<=`cnt`+1.
- RUN exit: go to DONE when `mplier[63:1]`==0 (the shifted multiplier would be zero) or `cnt`==63. Otherwise stay in RUN.
- DONE, for one cycle:
  - `done`=1 and `result` = `acc`.
  - `result` is registered on the RUN→DONE edge from `alu_r`.
  - Next state is IDLE unconditionally.
- Arithmetic:
  - Both operands are treated as raw 64-bit patterns, so signed and unsigned low products are identical.
  - The ALU `CarryOut`, `Overflow` and `zero` outputs are ignored; product bits above 63 are discarded.
- Outside RUN: `alu_a`=0, `alu_b`=0, `alu_op`=4'b0010.
- `start` while `busy`=1 is ignored; it is neither queued nor reported.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `state`=IDLE.
  - `busy`=0, `done`=0, `result`=0.
  - `acc`, `mcand`, `mplier` and `cnt` all clear to 0.
- Iteration count N = (index of highest set bit of `op_b`) + 1; N=1 when `op_b`=0; N≤64.
- Timeline, with the start edge as cycle 0:
  - RUN occupies cycles 1..N.
  - `done`=1 in cycle N+1.
  - IDLE is re-entered in cycle N+2, where a new `start` is accepted.
- `busy` rises the cycle after `start` is sampled and falls together with `done`.
- Reset mid-operation: abort immediately, no `done` pulse, and `result` is cleared to 0.
- `op_a` and `op_b` are sampled only on the start edge; later changes to them have no effect.

## Test plan
- `op_a`=20, `op_b`=120, `start` pulse → `done` in cycle 8 (N=7), `result`=2400, `busy` high for cycles 1–8.
- `op_a`=-5, `op_b`=3 → `done` in cycle 3, `result`=64'hFFFF_FFFF_FFFF_FFF1 (-15).
- `op_a`=7, `op_b`=-1 → N=64, `done` in cycle 65, `result`=-7; check `cnt` wrap terminates RUN.
- `op_a`=2^62, `op_b`=4 → `result`=0 (truncation), no error indication; then `op_b`=0 → `done` in cycle 2, `result`=0.
- Second `start` asserted during RUN of `op_a`=9, `op_b`=9 → ignored, `result`=81, exactly one `done`; `start` at cycle N+2 is accepted.
- Assert `rst_n`=0 at cycle 4 of a 64-iteration job → `busy`, `done`, `result` are 0 immediately and `alu_a`/`alu_b` are 0; after release, a new job completes correctly.

Source files
------------

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - radix-2 shift-add 64-bit multiply sequencer driving the shared ALU adder
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [63:0] alu_r
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [63:0] mplier;
  logic [5:0]  cnt;
  logic        run_last;

  // Stop as soon as no multiplier bits remain, or after the 64th step.
  assign run_last = (mplier[63:1] == 63'd0) || (cnt == 6'd63);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= 64'd0;
      mcand  <= 64'd0;
      mplier <= 64'd0;
      cnt    <= 6'd0;
      result <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= 64'd0;
            mcand  <= op_a;
            mplier <= op_b;
            cnt    <= 6'd0;
          end
        end
        RUN: begin
          acc    <= alu_r;
          mcand  <= {mcand[62:0], 1'b0};
          mplier <= {1'b0, mplier[63:1]};
          cnt    <= cnt + 6'd1;
          if (run_last) begin
            result <= alu_r;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_a     = 64'd0;
    alu_b     = 64'd0;
    alu_op    = 4'b0010;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        alu_a = acc;
        alu_b = mplier[0] ? mcand : 64'd0;
        if (run_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
